// File: rtl/seq_controller_if.sv
// ---------------------------------------------------------------------------
// seq_controller_if
// Bundles the sequencer's control inputs and status outputs.
//   run     : step enable (single-step when pulsed)
//   opcode  : instruction-register opcode
//   flag_c  : carry flag
//   flag_z  : zero flag
//   out     : control word (CW_W bits)
//   step    : current T-step (STEP_W bits)
//   halted  : halt latch
// Modports: master drives run/opcode/flags, slave (the controller) drives
// out/step/halted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface seq_controller_if #(
    parameter int CW_W   = 16,
    parameter int STEP_W = 3
);
    logic              run;
    logic [3:0]        opcode;
    logic              flag_c;
    logic              flag_z;
    logic [CW_W-1:0]   out;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        output run, opcode, flag_c, flag_z,
        input  out, step, halted
    );

    modport slave (
        input  run, opcode, flag_c, flag_z,
        output out, step, halted
    );
endinterface

// File: rtl/seq_controller.sv
// ---------------------------------------------------------------------------
// seq_controller
// Microcode sequencer for a small 8-bit CPU. A T-step counter walks through
// fetch (T0-T2) and execute (T3-T5) steps; the control word is a purely
// combinational decode of step, opcode and flags.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_controller_if.slave (run, opcode, flag_c, flag_z in;
//          out, step, halted out)
// Parameters:
//   CW_W   : control-word width, 12 (legacy) or 16 (extended)
//   STEP_W : step-counter width, >= 3
// Build option:
//   SEQ_EARLY_END_EN : when defined, short instructions wrap after T3/T4
//                      instead of always running to T5.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_controller #(
    parameter int CW_W   = 16,
    parameter int STEP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    seq_controller_if.slave  bus
);
    // Opcodes
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_JC  = 4'b0110;
    localparam logic [3:0] OP_JZ  = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word bits (extended 16-bit layout)
    localparam logic [15:0] CW_ADDER_EN  = 16'h0001;
    localparam logic [15:0] CW_ADDER_SUB = 16'h0002;
    localparam logic [15:0] CW_B_LOAD    = 16'h0004;
    localparam logic [15:0] CW_A_EN      = 16'h0008;
    localparam logic [15:0] CW_A_LOAD    = 16'h0010;
    localparam logic [15:0] CW_IR_EN     = 16'h0020;
    localparam logic [15:0] CW_IR_LOAD   = 16'h0040;
    localparam logic [15:0] CW_MEM_EN    = 16'h0080;
    localparam logic [15:0] CW_MEM_LOAD  = 16'h0100;
    localparam logic [15:0] CW_PC_EN     = 16'h0200;
    localparam logic [15:0] CW_PC_INC    = 16'h0400;
    localparam logic [15:0] CW_HLT       = 16'h0800;
    localparam logic [15:0] CW_MEM_WRITE = 16'h1000;
    localparam logic [15:0] CW_PC_LOAD   = 16'h2000;
    localparam logic [15:0] CW_OUT_LOAD  = 16'h4000;
    localparam logic [15:0] CW_FLAGS_LD  = 16'h8000;

    localparam int  HLT_BIT  = 11;
    localparam bit  EXT_WORD = (CW_W == 16);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t              state_reg, state_next;
    logic [STEP_W-1:0]   step_reg, step_next;
    logic [STEP_W-1:0]   last_step;
    logic [15:0]         word_full;
    logic [CW_W-1:0]     out_gated;
    logic                halted;
    logic                unused_word;

    assign halted = (state_reg == ST_HALTED);

    // Final step of the current instruction, after which the counter wraps.
    always_comb begin
        last_step = STEP_W'(5);
`ifdef SEQ_EARLY_END_EN
        case (bus.opcode)
            OP_ADD, OP_SUB: last_step = STEP_W'(5);
            OP_LDA, OP_STA: last_step = STEP_W'(4);
            default:        last_step = STEP_W'(3);
        endcase
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    // Next-state logic: the halt latch freezes the counter at T3.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        if (state_reg == ST_RUN && bus.run) begin
            if (step_reg == STEP_W'(3) && bus.opcode == OP_HLT) begin
                state_next = ST_HALTED;
            end else if (step_reg >= last_step) begin
                step_next = '0;
            end else begin
                step_next = step_reg + STEP_W'(1);
            end
        end
    end

    // Control-word decode (always computed in the 16-bit layout).
    always_comb begin
        word_full = '0;
        case (step_reg)
            STEP_W'(0): word_full = CW_PC_EN | CW_MEM_LOAD;
            STEP_W'(1): word_full = CW_PC_INC;
            STEP_W'(2): word_full = CW_MEM_EN | CW_IR_LOAD;
            STEP_W'(3): begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        word_full = CW_IR_EN | CW_MEM_LOAD;
                    OP_LDI: word_full = CW_IR_EN | CW_A_LOAD;
                    OP_JMP: word_full = CW_IR_EN | CW_PC_LOAD;
                    OP_JC:  word_full = bus.flag_c ? (CW_IR_EN | CW_PC_LOAD) : 16'h0000;
                    OP_JZ:  word_full = bus.flag_z ? (CW_IR_EN | CW_PC_LOAD) : 16'h0000;
                    OP_OUT: word_full = CW_A_EN | CW_OUT_LOAD;
                    OP_HLT: word_full = CW_HLT;
                    default: word_full = '0;
                endcase
            end
            STEP_W'(4): begin
                case (bus.opcode)
                    OP_LDA:         word_full = CW_MEM_EN | CW_A_LOAD;
                    OP_ADD, OP_SUB: word_full = CW_MEM_EN | CW_B_LOAD;
                    OP_STA:         word_full = CW_A_EN | CW_MEM_WRITE;
                    default:        word_full = '0;
                endcase
            end
            STEP_W'(5): begin
                case (bus.opcode)
                    OP_ADD: word_full = CW_ADDER_EN | CW_A_LOAD | CW_FLAGS_LD;
                    OP_SUB: word_full = CW_ADDER_EN | CW_ADDER_SUB | CW_A_LOAD | CW_FLAGS_LD;
                    default: word_full = '0;
                endcase
            end
            default: word_full = '0;
        endcase

        // The legacy word has no store/jump/output paths: those opcodes
        // execute as NOP once fetch is done.
        if (!EXT_WORD && step_reg >= STEP_W'(3)) begin
            case (bus.opcode)
                OP_STA, OP_JMP, OP_JC, OP_JZ, OP_OUT: word_full = '0;
                default: ;
            endcase
        end
    end

    // Upper bits are simply not present in the legacy word (drops FLAGS_LOAD).
    assign unused_word = ^word_full;

    // Output gating: silent in reset and stalls; only HLT survives a halt.
    generate
        for (genvar gi = 0; gi < CW_W; gi++) begin : g_out
            assign out_gated[gi] = rst    ? 1'b0 :
                                   halted ? ((gi == HLT_BIT) ? 1'b1 : 1'b0) :
                                            (bus.run & word_full[gi]);
        end
    endgenerate

    assign bus.out    = out_gated;
    assign bus.step   = step_reg;
    assign bus.halted = halted;

endmodule

// File: tb/tb_seq_controller.sv
`timescale 1ns/1ps
module tb_seq_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_controller_if #(.CW_W(16), .STEP_W(3)) bus16 ();
    seq_controller_if #(.CW_W(12), .STEP_W(3)) bus12 ();

    seq_controller #(.CW_W(16), .STEP_W(3)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    seq_controller #(.CW_W(12), .STEP_W(3)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] o16;
        logic [11:0] o12;
        logic [2:0]  st;
        logic        hl;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic txn_t mk(logic r, logic [3:0] op, logic c, logic z,
                                logic [15:0] o16, logic [11:0] o12,
                                logic [2:0] st, logic hl);
        txn_t t;
        t.run = r; t.op = op; t.c = c; t.z = z;
        t.o16 = o16; t.o12 = o12; t.st = st; t.hl = hl;
        return t;
    endfunction

    // Drive one transaction after a falling edge and record its expectation.
    task automatic apply(input txn_t t);
        @(negedge clk);
        bus16.run = t.run; bus16.opcode = t.op; bus16.flag_c = t.c; bus16.flag_z = t.z;
        bus12.run = t.run; bus12.opcode = t.op; bus12.flag_c = t.c; bus12.flag_z = t.z;
        sb.push_back(t);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus16.run = 1'b0; bus12.run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus16.run = 1'b1; bus16.opcode = 4'h1; bus16.flag_c = 1'b0; bus16.flag_z = 1'b0;
        bus12.run = 1'b1; bus12.opcode = 4'h1; bus12.flag_c = 1'b0; bus12.flag_z = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            $display("reset[%0d] step=%0d halted=%0b out16=%h out12=%h",
                     i, bus16.step, bus16.halted, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !== 36'h0)
                $display("FAIL reset[%0d]: got out16=%h out12=%h step=%0d halted=%0b, want all zero",
                         i, bus16.out, bus12.out, bus16.step, bus16.halted);
            else
                passes++;
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        txn_t tbl[$];
        txn_t e;
        do_reset();
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h0120, 12'h120, 3, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h0084, 12'h084, 4, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h8011, 12'h011, 5, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 16'h0300, 12'h300, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            $display("add[%0d] step=%0d out16=%h out12=%h", i, bus16.step, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL add[%0d]: got out16=%h out12=%h step=%0d, want out16=%h out12=%h step=%0d",
                         i, bus16.out, bus12.out, bus16.step, e.o16, e.o12, e.st);
            else
                passes++;
        end
    endtask

    task automatic test_cond_jump();
        txn_t tbl[$];
        txn_t e;
        // JC c=0, JC c=1, JZ z=0 (c=1), JZ z=1
        logic [3:0]  ops[4]  = '{4'h6, 4'h6, 4'h7, 4'h7};
        logic        cs[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        zs[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] t3[4]   = '{16'h0000, 16'h2020, 16'h0000, 16'h2020};
        for (int g = 0; g < 4; g++) begin
            tbl.push_back(mk(1, ops[g], cs[g], zs[g], 16'h0300, 12'h300, 0, 0));
            tbl.push_back(mk(1, ops[g], cs[g], zs[g], 16'h0400, 12'h400, 1, 0));
            tbl.push_back(mk(1, ops[g], cs[g], zs[g], 16'h00C0, 12'h0C0, 2, 0));
            tbl.push_back(mk(1, ops[g], cs[g], zs[g], t3[g],    12'h000, 3, 0));
        end
        foreach (tbl[i]) begin
            if (i % 4 == 0) do_reset();
            apply(tbl[i]);
            e = sb.pop_front();
            $display("cjump[%0d] op=%h c=%0b z=%0b step=%0d out16=%h out12=%h",
                     i, e.op, e.c, e.z, bus16.step, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL cjump[%0d]: got out16=%h out12=%h step=%0d, want out16=%h out12=%h step=%0d",
                         i, bus16.out, bus12.out, bus16.step, e.o16, e.o12, e.st);
            else
                passes++;
        end
    endtask

    task automatic test_halt();
        txn_t tbl[$];
        txn_t e;
        do_reset();
        tbl.push_back(mk(1, 4'hF, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'hF, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'hF, 0, 0, 16'h0800, 12'h800, 3, 0));
        tbl.push_back(mk(0, 4'h1, 0, 0, 16'h0800, 12'h800, 3, 1));
        tbl.push_back(mk(1, 4'h0, 1, 1, 16'h0800, 12'h800, 3, 1));
        tbl.push_back(mk(1, 4'h5, 0, 0, 16'h0800, 12'h800, 3, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            $display("halt[%0d] run=%0b op=%h step=%0d halted=%0b out16=%h out12=%h",
                     i, e.run, e.op, bus16.step, bus16.halted, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL halt[%0d]: got out16=%h step=%0d halted=%0b, want out16=%h step=%0d halted=%0b",
                         i, bus16.out, bus16.step, bus16.halted, e.o16, e.st, e.hl);
            else
                passes++;
        end
        // Reset between clock edges must clear the halt immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("halt_rst step=%0d halted=%0b out16=%h", bus16.step, bus16.halted, bus16.out);
        checks++;
        if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !== 36'h0)
            $display("FAIL halt_rst: got out16=%h step=%0d halted=%0b, want 0/0/0",
                     bus16.out, bus16.step, bus16.halted);
        else
            passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stall();
        txn_t tbl[$];
        txn_t e;
        int   pc_inc_seen = 0;
        do_reset();
        tbl.push_back(mk(1, 4'h0, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 16'h0000, 12'h000, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 16'h0000, 12'h000, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 16'h0120, 12'h120, 3, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 16'h0090, 12'h090, 4, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            if (bus16.out[10] === 1'b1) pc_inc_seen++;
            $display("stall[%0d] run=%0b step=%0d out16=%h out12=%h",
                     i, e.run, bus16.step, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL stall[%0d]: got out16=%h out12=%h step=%0d, want out16=%h out12=%h step=%0d",
                         i, bus16.out, bus12.out, bus16.step, e.o16, e.o12, e.st);
            else
                passes++;
        end
        checks++;
        if (pc_inc_seen !== 1)
            $display("FAIL stall_pc_inc: got %0d PC_INC cycles, want 1", pc_inc_seen);
        else
            passes++;
    endtask

    task automatic test_step_length();
        txn_t tbl[$];
        txn_t e;
        do_reset();
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0030, 12'h030, 3, 0));
`ifndef SEQ_EARLY_END_EN
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0000, 12'h000, 4, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0000, 12'h000, 5, 0));
`endif
        tbl.push_back(mk(1, 4'h4, 0, 0, 16'h0300, 12'h300, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            $display("ldi[%0d] step=%0d out16=%h out12=%h", i, bus16.step, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL ldi[%0d]: got out16=%h out12=%h step=%0d, want out16=%h out12=%h step=%0d",
                         i, bus16.out, bus12.out, bus16.step, e.o16, e.o12, e.st);
            else
                passes++;
        end
    endtask

    task automatic test_back_to_back();
        txn_t tbl[$];
        txn_t e;
        do_reset();
        // STA (legacy word: NOP after fetch)
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h0120, 12'h000, 3, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h1008, 12'h000, 4, 0));
`ifndef SEQ_EARLY_END_EN
        tbl.push_back(mk(1, 4'h3, 0, 0, 16'h0000, 12'h000, 5, 0));
`endif
        // OUT immediately following
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h4008, 12'h000, 3, 0));
`ifndef SEQ_EARLY_END_EN
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h0000, 12'h000, 4, 0));
        tbl.push_back(mk(1, 4'hE, 0, 0, 16'h0000, 12'h000, 5, 0));
`endif
        // JMP after that, through T3
        tbl.push_back(mk(1, 4'h5, 0, 0, 16'h0300, 12'h300, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 0, 16'h0400, 12'h400, 1, 0));
        tbl.push_back(mk(1, 4'h5, 0, 0, 16'h00C0, 12'h0C0, 2, 0));
        tbl.push_back(mk(1, 4'h5, 0, 0, 16'h2020, 12'h000, 3, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            $display("b2b[%0d] op=%h step=%0d out16=%h out12=%h",
                     i, e.op, bus16.step, bus16.out, bus12.out);
            checks++;
            if ({bus16.out, bus12.out, bus16.step, bus12.step, bus16.halted, bus12.halted} !==
                {e.o16, e.o12, e.st, e.st, e.hl, e.hl})
                $display("FAIL b2b[%0d]: got out16=%h out12=%h step=%0d, want out16=%h out12=%h step=%0d",
                         i, bus16.out, bus12.out, bus16.step, e.o16, e.o12, e.st);
            else
                passes++;
        end
    endtask

    initial begin
        bus16.run = 1'b0; bus16.opcode = 4'h0; bus16.flag_c = 1'b0; bus16.flag_z = 1'b0;
        bus12.run = 1'b0; bus12.opcode = 4'h0; bus12.flag_c = 1'b0; bus12.flag_z = 1'b0;
        test_reset();
        test_add();
        test_cond_jump();
        test_halt();
        test_stall();
        test_step_length();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns, want completion");
        $fatal(1);
    end
endmodule
